// File: rtl/debug_word_sender.sv
`default_nettype none
// ============================================================================
// Module      : debug_word_sender
// Description : Buffers 32-bit debug words in a small FIFO and streams each
//               one, least-significant byte first, into a tx_uart transmitter
//               using its tx_start / tx_done_tick handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_word_sender #(
    parameter int NB_DATA    = 32,
    parameter int N_BITS     = 8,
    parameter int N_BYTES    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               wr_en_i,
    input  logic [NB_DATA-1:0] data_i,
    output logic               full_o,
    output logic               overflow_o,
    input  logic               tx_done_tick_i,
    output logic               tx_start_o,
    output logic [N_BITS-1:0]  din_o,
    output logic               read_tx_o,
    output logic               busy_o,
    output logic [7:0]         words_sent_o
);

    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_BCNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_BCNT_W-1:0] c_LAST_BYTE = c_BCNT_W'(N_BYTES - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_START = 2'd2;
    localparam logic [1:0] c_WAIT  = 2'd3;

    logic [NB_DATA-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [NB_DATA-1:0]  r_shift;
    logic [c_BCNT_W-1:0] r_byte_cnt;
    logic [7:0]          r_words_sent;
    logic                w_pop;
    logic                w_push;
    logic                w_last_byte;

    // FIFO handshake: LOAD is the only pop, and a pop frees a slot for a same-cycle push
    always_comb begin
        w_pop       = (r_state == c_LOAD);
        w_push      = wr_en_i && ((r_count != c_FULL_CNT) || w_pop);
        w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    end

    // Word storage; contents are don't-care until written, so no reset
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en_i && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer next-state logic; done ticks only matter while waiting on a byte
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (r_count != '0) w_state_next = c_LOAD;
            c_LOAD:  w_state_next = c_START;
            c_START: w_state_next = c_WAIT;
            c_WAIT:  if (tx_done_tick_i) w_state_next = w_last_byte ? c_IDLE : c_START;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Byte shifter, byte index and completed-word counter
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_words_sent <= '0;
        end else begin
            case (r_state)
                c_LOAD: begin
                    r_shift    <= r_mem[r_rd_ptr];
                    r_byte_cnt <= '0;
                end
                c_WAIT: begin
                    if (tx_done_tick_i) begin
                        if (w_last_byte) begin
                            r_words_sent <= r_words_sent + 1'b1;
                        end else begin
                            r_shift    <= r_shift >> N_BITS;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_shift <= r_shift;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only; din follows the shifter's low byte,
    // which only moves on the way into START
    always_comb begin
        tx_start_o   = (r_state == c_START);
        read_tx_o    = (r_state != c_IDLE);
        busy_o       = (r_state != c_IDLE) || (r_count != '0);
        full_o       = (r_count == c_FULL_CNT);
        overflow_o   = r_overflow;
        din_o        = r_shift[N_BITS-1:0];
        words_sent_o = r_words_sent;
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_word_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_word_sender
// Description : Self-checking bench for debug_word_sender: randomized and
//               directed stimulus against a queue-based timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_word_sender;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] data_i  = '0;
    logic        tx_done_tick_i = 1'b0;
    logic        full_o, overflow_o, tx_start_o, read_tx_o, busy_o;
    logic [7:0]  din_o, words_sent_o;

    debug_word_sender #(
        .NB_DATA(32), .N_BITS(8), .N_BYTES(4), .FIFO_DEPTH(4)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .wr_en_i(wr_en_i), .data_i(data_i),
        .full_o(full_o), .overflow_o(overflow_o), .tx_done_tick_i(tx_done_tick_i),
        .tx_start_o(tx_start_o), .din_o(din_o), .read_tx_o(read_tx_o),
        .busy_o(busy_o), .words_sent_o(words_sent_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_q[$];
    logic [7:0]  m_bytes[$];
    bit          m_valid = 0, m_active = 0, m_wait = 0, m_ovf = 0;
    int          m_load_at = -1, m_start_at = -1;
    logic [7:0]  m_din = '0, m_sent = '0;
    bit          m_pop, m_was_active;
    int          m_qsz;
    logic [31:0] m_w;

    always @(negedge clock_i) begin
        if (m_valid) begin
            chk("tx_start", tx_start_o, (m_active && cyc == m_start_at));
            chk("din", din_o, m_din);
            chk("read_tx", read_tx_o, m_active);
            chk("busy", busy_o, (m_active || m_q.size() != 0));
            chk("full", full_o, (m_q.size() == 4));
            chk("overflow", overflow_o, m_ovf);
            chk("words_sent", words_sent_o, m_sent);
        end
        if (reset_i) begin
            m_valid = 1; m_active = 0; m_wait = 0; m_ovf = 0;
            m_load_at = -1; m_start_at = -1; m_din = '0; m_sent = '0;
            m_q.delete(); m_bytes.delete();
        end else if (m_valid) begin
            m_was_active = m_active;
            m_qsz = m_q.size();
            m_pop = m_active && (cyc == m_load_at);
            if (tx_done_tick_i && m_wait) begin
                m_wait = 0;
                if (m_bytes.size() > 1) begin
                    void'(m_bytes.pop_front());
                    m_din = m_bytes[0];
                    m_start_at = cyc + 1;
                end else begin
                    m_bytes.delete();
                    m_sent = m_sent + 8'd1;
                    m_active = 0;
                end
            end
            if (m_was_active && cyc == m_start_at) m_wait = 1;
            if (m_pop) begin
                m_w = m_q.pop_front();
                m_bytes.delete();
                for (int b = 0; b < 4; b++) m_bytes.push_back(m_w[8*b +: 8]);
                m_din = m_bytes[0];
                m_start_at = cyc + 1;
            end
            if (!m_was_active && m_qsz != 0) begin
                m_active = 1;
                m_load_at = cyc + 1;
            end
            if (wr_en_i) begin
                if (m_qsz < 4 || m_pop) m_q.push_back(data_i);
                else m_ovf = 1;
            end
        end
    end

    // ---------------- start-pulse log ----------------
    int         st_cyc[$];
    logic [7:0] st_din[$];
    always @(negedge clock_i) begin
        if (tx_start_o === 1'b1) begin
            st_cyc.push_back(cyc);
            st_din.push_back(din_o);
        end
    end

    // ---------------- driver with tx_uart responder ----------------
    int tick_at = -1;
    bit auto_resp = 0;
    int fixed_delay = 0;

    task automatic drive(input bit we, input logic [31:0] d, input bit rst, input bit spur);
        if (tx_start_o === 1'b1)
            tick_at = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4)));
        wr_en_i = we;
        data_i = d;
        reset_i = rst;
        tx_done_tick_i = spur || (auto_resp && !rst && cyc == tick_at);
        if (rst) tick_at = -1;
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    logic [7:0]  exp_din [4];
    logic [31:0] words [6];
    int t0, k, pushed;
    bit we;

    initial begin
        exp_din[0] = 8'hD4; exp_din[1] = 8'hC3; exp_din[2] = 8'hB2; exp_din[3] = 8'hA1;
        @(posedge clock_i); #1;
        repeat (3) drive(0, '0, 1, 0);

        // reset values
        chk("rst_tx_start", tx_start_o, 0);
        chk("rst_din", din_o, 0);
        chk("rst_read_tx", read_tx_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_words_sent", words_sent_o, 0);

        // single word, responder answers 10 cycles after each start
        fixed_delay = 10; auto_resp = 1;
        st_cyc.delete(); st_din.delete();
        t0 = cyc;
        drive(1, 32'hA1B2C3D4, 0, 0);
        for (int i = 0; i < 60; i++) begin
            if (cyc == t0 + 46) chk("single_busy_at_last_tick", busy_o, 1);
            if (cyc == t0 + 47) chk("single_busy_after_last_tick", busy_o, 0);
            drive(0, '0, 0, 0);
        end
        chk("single_start_count", st_cyc.size(), 4);
        if (st_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("single_din_order", st_din[i], exp_din[i]);
                chk("single_start_cycle", st_cyc[i], t0 + 3 + 11 * i);
            end
        end
        chk("single_words_sent", words_sent_o, 1);

        // spurious tick while idle
        drive(0, '0, 0, 1);
        repeat (3) drive(0, '0, 0, 0);
        chk("spur_idle_words", words_sent_o, 1);
        chk("spur_idle_busy", busy_o, 0);
        chk("spur_idle_no_start", st_cyc.size(), 4);

        // fill, then push in the same cycle LOAD pops
        auto_resp = 0; fixed_delay = 2;
        for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0);
        chk("coll_full_before", full_o, 1);
        chk("coll_ovf_before", overflow_o, 0);
        auto_resp = 1;
        drive(0, '0, 0, 1);
        k = 0;
        while (words_sent_o != 8'd2 && k < 200) begin
            drive(0, '0, 0, tx_start_o);   // tick during START must be ignored
            k++;
        end
        chk("coll_word_done_timeout", (k < 200), 1);
        drive(0, '0, 0, 0);                 // IDLE
        drive(1, $urandom, 0, 0);           // LOAD: pop and push together
        chk("coll_full_after", full_o, 1);
        chk("coll_ovf_after", overflow_o, 0);
        chk("coll_start", tx_start_o, 1);

        // overflow: six back-to-back pushes, no done ticks
        drive(0, '0, 1, 0); drive(0, '0, 1, 0);
        auto_resp = 0;
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        t0 = cyc;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                chk("ovf_first_start", tx_start_o, 1);
                chk("ovf_first_din", din_o, words[0][7:0]);
            end
            if (i == 4) chk("ovf_full_t4", full_o, 0);
            if (i == 5) begin
                chk("ovf_full_t5", full_o, 1);
                chk("ovf_flag_t5", overflow_o, 0);
            end
            if (i >= 6) begin
                chk("ovf_flag_late", overflow_o, 1);
                chk("ovf_full_late", full_o, 1);
            end
            drive(i < 6, (i < 6) ? words[i] : 32'h0, 0, 0);
        end

        // reset during WAIT of the second byte
        drive(0, '0, 1, 0); drive(0, '0, 1, 0);
        auto_resp = 1; fixed_delay = 3;
        st_cyc.delete(); st_din.delete();
        drive(1, $urandom, 0, 0);
        drive(1, $urandom, 0, 0);
        k = 0;
        while (st_cyc.size() < 2 && k < 100) begin
            drive(0, '0, 0, 0);
            k++;
        end
        chk("midrst_second_start_timeout", (k < 100), 1);
        drive(0, '0, 1, 0);
        chk("midrst_tx_start", tx_start_o, 0);
        chk("midrst_din", din_o, 0);
        chk("midrst_read_tx", read_tx_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_full", full_o, 0);
        chk("midrst_words", words_sent_o, 0);
        repeat (20) drive(0, '0, 0, 0);
        chk("midrst_no_more_starts", st_cyc.size(), 2);
        chk("midrst_idle_busy", busy_o, 0);

        // 256 random words with random response latency and stray ticks
        drive(0, '0, 1, 0); drive(0, '0, 1, 0);
        fixed_delay = 0; auto_resp = 1;
        pushed = 0; k = 0;
        while ((pushed < 256 || busy_o) && k < 30000) begin
            we = (pushed < 256) && !full_o && ($urandom_range(0, 1) == 1);
            drive(we, $urandom, 0, ($urandom_range(0, 15) == 0));
            if (we) pushed++;
            k++;
        end
        chk("wrap_timeout", (k < 30000), 1);
        chk("wrap_words_sent", words_sent_o, 0);
        chk("wrap_overflow", overflow_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_word_sender.md
# debug_word_sender

Sequencer that turns 32-bit debug words into back-to-back UART bytes. It sits between the debug unit's word source and the `tx_uart` transmitter, driving that transmitter's `tx_start`, `din` and `read_tx` inputs and consuming its `tx_done_tick`. It buffers up to `FIFO_DEPTH` words, so the debug unit can push register or memory dumps without waiting on the 8N1 line rate.

## Interface
- `NB_DATA`, 32: width of a pushed word.
- `N_BITS`, 8: UART byte width.
- `N_BYTES`, 4: bytes per word, equal to NB_DATA/N_BITS.
- `FIFO_DEPTH`, 4: word buffer depth; must be a power of two.
- `clock_i`, in, 1: single clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `wr_en_i`, in, 1: push `data_i` this cycle.
- `data_i`, in, NB_DATA: word to send.
- `full_o`, out, 1: FIFO holds FIFO_DEPTH words (combinational from count).
- `overflow_o`, out, 1: sticky; set when a push is dropped.
- `tx_done_tick_i`, in, 1: one-cycle pulse from tx_uart marking the end of a byte.
- `tx_start_o`, out, 1: one-cycle pulse that starts a byte in tx_uart.
- `din_o`, out, N_BITS: byte presented to tx_uart.
- `read_tx_o`, out, 1: tx_uart enable; high in every state except IDLE.
- `busy_o`, out, 1: high when state ≠ IDLE or the FIFO is non-empty.
- `words_sent_o`, out, 8: count of fully sent words; wraps 255→0.

## Operation
- **FIFO**
  - Circular buffer with registered read and write pointers and a count.
  - A push is accepted iff count < FIFO_DEPTH, or a pop occurs in the same cycle.
  - A push while full with no pop is dropped and sets `overflow_o`. Only reset clears `overflow_o`.
- **FSM states:** IDLE, LOAD, START, WAIT.
  - IDLE: if count ≠ 0, go to LOAD.
  - LOAD: pop the head word into a shift register, set byte_cnt=0, go to START.
  - START: `tx_start_o`=1 for exactly this cycle; `din_o` = shift[N_BITS-1:0]; go to WAIT.
  - WAIT: hold `din_o`.
    - On `tx_done_tick_i` with byte_cnt < N_BYTES-1: shift right by N_BITS, increment byte_cnt, go to START.
    - On `tx_done_tick_i` with byte_cnt = N_BYTES-1: increment `words_sent_o`, go to IDLE.
- **Byte order:** little-endian, so bits [7:0] are sent first and bits [31:24] last.
- `tx_done_tick_i` outside WAIT is ignored.
- **Reset mid-transfer:** the word in flight is abandoned, the FIFO is emptied and the FSM returns to IDLE. tx_uart shares the same reset.

## Timing
- **Reset values:** all outputs 0. State IDLE, pointers and count 0, shift register 0.
- **Push latency:** a push in cycle t into an empty FIFO with the FSM in IDLE gives:
  - cycle t+1: count=1;
  - cycle t+2: LOAD (pop at end of cycle);
  - cycle t+3: first `tx_start_o` pulse.
- **Inter-byte gap:** a done tick in cycle d gives START, i.e. the next `tx_start_o`, in cycle d+1.
- **Between words:** last done tick in cycle d → IDLE in d+1 → LOAD in d+2 → START in d+3.
- `din_o` changes only on entry to START, and never while in WAIT.
- `full_o` and `busy_o` reflect registered state and carry no same-cycle dependence on `wr_en_i`.

## Test plan
- **Single word:** after reset, push 0xA1B2C3D4. Answer each `tx_start_o` with a `tx_done_tick_i` 10 cycles later. Required:
  - `din_o` sequence D4, C3, B2, A1;
  - exactly 4 start pulses, first in cycle t+3;
  - `words_sent_o`=1;
  - `busy_o` low 1 cycle after the last tick.
- **Overflow:** push in 6 consecutive cycles starting at cycle t, never ticking done. Required:
  - pop of word 1 in cycle t+2;
  - words 2–5 buffered and `full_o`=1 from cycle t+5;
  - word 6 dropped and `overflow_o`=1 from cycle t+6 onward.
- **Push/pop collision:** fill the FIFO (full), then push in the same cycle LOAD pops. Required: push accepted, `full_o` stays 1, `overflow_o` stays 0.
- **Spurious tick:** pulse `tx_done_tick_i` while IDLE and while in START. Required: no state, byte_cnt or counter change.
- **Reset mid-word:** push two words, assert `reset_i` during WAIT of byte 2. Required:
  - next cycle all outputs 0;
  - count 0;
  - no further `tx_start_o` until a new push.
- **Counter wrap:** send 256 words. Required: `words_sent_o` returns to 0 and byte order stays correct throughout.
